// File: rtl/mem_port_arbiter.sv
// Round-robin N-client front end for the single main-memory port, one transaction at a time.
// Define ARB_TIMEOUT_EN to add a WAIT-state watchdog that completes the transaction with an error.
module mem_port_arbiter #(
    parameter int unsigned NUM_CLIENTS      = 2,
    parameter int unsigned ADDR_WIDTH       = 20,
    parameter int unsigned DATA_LEN         = 32,
    parameter int unsigned ENTRY_INDEX_SIZE = 3,
    parameter int unsigned TIMEOUT_CYCLES   = 256
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [2*NUM_CLIENTS-1:0]                    client_vis_signal,
    input  logic [ADDR_WIDTH*NUM_CLIENTS-1:0]           client_addr,
    input  logic [DATA_LEN*NUM_CLIENTS-1:0]             client_written_data,
    input  logic [3*NUM_CLIENTS-1:0]                    client_data_type,
    input  logic [(ENTRY_INDEX_SIZE+1)*NUM_CLIENTS-1:0] client_length,
    output logic [2*NUM_CLIENTS-1:0]                    client_status,
    output logic [DATA_LEN-1:0]                         client_rdata,
    output logic [1:0]                                  mem_vis_signal,
    output logic [ADDR_WIDTH-1:0]                       mem_vis_addr,
    output logic [DATA_LEN-1:0]                         mem_written_data,
    output logic [2:0]                                  mem_data_type,
    output logic [ENTRY_INDEX_SIZE:0]                   mem_write_length,
    input  logic [DATA_LEN-1:0]                         mem_data,
    input  logic [1:0]                                  mem_status
);

    localparam int unsigned PtrW  = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1;
    localparam int unsigned PtrW1 = PtrW + 1;
    localparam int unsigned LenW  = ENTRY_INDEX_SIZE + 1;

    if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_port_arbiter: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StDone,
        StRecover
    } state_e;

    state_e                 state_q, state_d;
    logic [PtrW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PtrW-1:0]        grant_q, grant_d;
    logic [1:0]             mem_vis_q, mem_vis_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_LEN-1:0]    mem_wdata_q, mem_wdata_d;
    logic [2:0]             mem_type_q, mem_type_d;
    logic [LenW-1:0]        mem_len_q, mem_len_d;
    logic [DATA_LEN-1:0]    rdata_q, rdata_d;
    logic [2*NUM_CLIENTS-1:0] status_q, status_d;

    logic [NUM_CLIENTS-1:0] req_vec;
    logic                   found;
    logic [PtrW-1:0]        win;
    logic [PtrW:0]          cand;
    logic [PtrW:0]          nxt;
    logic [1:0]             done_code;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // 11 encodes idle, so only the two legal op codes count as a request.
    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            req_vec[i] = ^client_vis_signal[2*i +: 2];
        end
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            cand = {1'b0, rr_ptr_q} + PtrW1'(i);
            if (cand >= PtrW1'(NUM_CLIENTS)) begin
                cand = cand - PtrW1'(NUM_CLIENTS);
            end
            if (!found && req_vec[cand[PtrW-1:0]]) begin
                found = 1'b1;
                win   = cand[PtrW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        mem_vis_d   = 2'b00;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_type_d  = mem_type_q;
        mem_len_d   = mem_len_q;
        rdata_d     = rdata_q;
        done_code   = 2'b10;
        nxt         = '0;
        status_d    = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d     = StIssue;
                    grant_d     = win;
                    mem_vis_d   = client_vis_signal[2*win +: 2];
                    mem_addr_d  = client_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_d = client_written_data[win*DATA_LEN +: DATA_LEN];
                    mem_type_d  = client_data_type[3*win +: 3];
                    mem_len_d   = client_length[win*LenW +: LenW];
                end
            end
            StIssue: begin
                state_d = StWait;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWait: begin
                if (mem_status == 2'b10) begin
                    state_d     = StDone;
                    rdata_d     = mem_data;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_type_d  = '0;
                    mem_len_d   = '0;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = StDone;
                    done_code   = 2'b11;
                    rdata_d     = '0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_type_d  = '0;
                    mem_len_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
`endif
                end
            end
            StDone: begin
                state_d = StRecover;
                nxt     = {1'b0, grant_q} + PtrW1'(1);
                if (nxt >= PtrW1'(NUM_CLIENTS)) begin
                    nxt = '0;
                end
                rr_ptr_d = nxt[PtrW-1:0];
            end
            StRecover: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status is registered against the state being entered; the served client is quiet in
        // RECOVER so a stale request it has not yet dropped does not read as busy.
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (PtrW'(i) == grant_d && state_d != StIdle && state_d != StRecover) begin
                status_d[2*i +: 2] = (state_d == StDone) ? done_code : 2'b01;
            end else if (PtrW'(i) != grant_d && state_d != StIdle && req_vec[i]) begin
                status_d[2*i +: 2] = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            mem_vis_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_type_q  <= '0;
            mem_len_q   <= '0;
            rdata_q     <= '0;
            status_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            mem_vis_q   <= mem_vis_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_type_q  <= mem_type_d;
            mem_len_q   <= mem_len_d;
            rdata_q     <= rdata_d;
            status_q    <= status_d;
        end
    end

    assign client_status    = status_q;
    assign client_rdata     = rdata_q;
    assign mem_vis_signal   = mem_vis_q;
    assign mem_vis_addr     = mem_addr_q;
    assign mem_written_data = mem_wdata_q;
    assign mem_data_type    = mem_type_q;
    assign mem_write_length = mem_len_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with three clients; the watchdog scenario runs only
// when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic [5:0]  vis;
    logic [59:0] caddr;
    logic [95:0] cwdata;
    logic [8:0]  ctype;
    logic [11:0] clen;
    logic [5:0]  status;
    logic [31:0] rdata;
    logic [1:0]  mvis;
    logic [19:0] maddr;
    logic [31:0] mwdata;
    logic [2:0]  mtype;
    logic [3:0]  mlen;
    logic [31:0] mdata;
    logic [1:0]  mstat;

    int checks = 0;
    int errors = 0;

    logic [19:0] exp_addr [3] = '{20'h00010, 20'h00020, 20'h00300};
    logic [5:0]  exp_st;

    mem_port_arbiter #(
        .NUM_CLIENTS     (3),
        .ADDR_WIDTH      (20),
        .DATA_LEN        (32),
        .ENTRY_INDEX_SIZE(3),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .client_vis_signal  (vis),
        .client_addr        (caddr),
        .client_written_data(cwdata),
        .client_data_type   (ctype),
        .client_length      (clen),
        .client_status      (status),
        .client_rdata       (rdata),
        .mem_vis_signal     (mvis),
        .mem_vis_addr       (maddr),
        .mem_written_data   (mwdata),
        .mem_data_type      (mtype),
        .mem_write_length   (mlen),
        .mem_data           (mdata),
        .mem_status         (mstat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_client(input int c, input logic [1:0] op, input logic [19:0] a,
                              input logic [31:0] d, input logic [2:0] t, input logic [3:0] l);
        vis[2*c +: 2]     = op;
        caddr[20*c +: 20] = a;
        cwdata[32*c +: 32] = d;
        ctype[3*c +: 3]   = t;
        clen[4*c +: 4]    = l;
    endtask

    initial begin
        rst    = 1'b0;
        vis    = '0;
        caddr  = '0;
        cwdata = '0;
        ctype  = '0;
        clen   = '0;
        mdata  = '0;
        mstat  = '0;

        // Reset held with requests pending
        set_client(0, 2'b10, 20'h00100, 32'h12345678, 3'b010, 4'b0001);
        set_client(2, 2'b01, 20'h00300, 32'h0, 3'b000, 4'b0000);
        step();
        step();
        chk("rst_status", status, 6'b0);
        chk("rst_mvis", mvis, 2'b00);
        chk("rst_maddr", maddr, 20'h0);
        chk("rst_mwdata", mwdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        rst = 1'b1;

        // Write pass-through to client 0; client 0 drops its request mid-transaction
        step();
        chk("wr_issue_vis", mvis, 2'b10);
        chk("wr_issue_addr", maddr, 20'h00100);
        chk("wr_issue_data", mwdata, 32'h12345678);
        chk("wr_issue_type", mtype, 3'b010);
        chk("wr_issue_len", mlen, 4'b0001);
        chk("wr_issue_status", status, 6'b010001);
        set_client(0, 2'b00, 20'hFFFFF, 32'hFFFFFFFF, 3'b111, 4'b1111);
        step();
        chk("wr_wait_vis", mvis, 2'b00);
        chk("wr_wait_addr", maddr, 20'h00100);
        chk("wr_wait_data", mwdata, 32'h12345678);
        chk("wr_wait_type", mtype, 3'b010);
        chk("wr_wait_len", mlen, 4'b0001);
        chk("wr_wait_status", status, 6'b010001);
        mstat = 2'b10;
        mdata = 32'h0BADF00D;
        step();
        chk("wr_done_status", status, 6'b010010);
        mstat = 2'b00;
        mdata = 32'h0;
        step();
        chk("wr_recover_status", status, 6'b010000);
        step();
        chk("idle_status", status, 6'b000000);

        // Client 2 granted next, then reset lands in WAIT
        step();
        chk("c2_issue_vis", mvis, 2'b01);
        chk("c2_issue_addr", maddr, 20'h00300);
        chk("c2_issue_status", status, 6'b010000);
        set_client(0, 2'b01, 20'h00010, 32'h0, 3'b000, 4'b0000);
        set_client(1, 2'b01, 20'h00020, 32'h0, 3'b000, 4'b0000);
        step();
        chk("c2_wait_status", status, 6'b010101);
        rst = 1'b0;
        #1;
        chk("midrst_status", status, 6'b0);
        chk("midrst_maddr", maddr, 20'h0);
        chk("midrst_rdata", rdata, 32'h0);
        step();
        chk("midrst_hold_status", status, 6'b0);
        chk("midrst_hold_mvis", mvis, 2'b00);
        rst = 1'b1;

        // Continuous contention: grants must rotate 0,1,2,0,1,2 from a cleared pointer
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_issue_vis", mvis, 2'b01);
            chk("rr_issue_addr", maddr, exp_addr[k % 3]);
            step();
            mstat = 2'b10;
            mdata = 32'hC0DE0000 + k;
            step();
            for (int i = 0; i < 3; i++) begin
                exp_st[2*i +: 2] = (i == k % 3) ? 2'b10 : 2'b01;
            end
            chk("rr_done_status", status, exp_st);
            chk("rr_done_rdata", rdata, 32'hC0DE0000 + k);
            mstat = 2'b00;
            if (k == 5) begin
                vis = '0;
            end
            step();
            step();
        end
        step();
        chk("noreq_status", status, 6'b0);
        chk("noreq_mvis", mvis, 2'b00);

        // Single read from client 1, memory answers 3 cycles after ISSUE
        set_client(1, 2'b01, 20'h00040, 32'h0, 3'b000, 4'b0000);
        step();
        chk("rd_c1_vis", mvis, 2'b01);
        chk("rd_c1_addr", maddr, 20'h00040);
        chk("rd_c1_status", status, 6'b000100);
        step();
        chk("rd_c2_vis", mvis, 2'b00);
        step();
        chk("rd_c3_status", status, 6'b000100);
        step();
        chk("rd_c4_status", status, 6'b000100);
        mstat = 2'b10;
        mdata = 32'hDEADBEEF;
        step();
        chk("rd_c5_status", status, 6'b001000);
        chk("rd_c5_rdata", rdata, 32'hDEADBEEF);
        mstat = 2'b00;
        mdata = 32'h0;
        vis   = '0;
        step();
        chk("rd_c6_status", status, 6'b000000);
        chk("rd_c6_rdata", rdata, 32'hDEADBEEF);
        step();

`ifdef ARB_TIMEOUT_EN
        // Watchdog: client 2 is next in rotation and memory never answers
        set_client(0, 2'b01, 20'h00010, 32'h0, 3'b000, 4'b0000);
        set_client(2, 2'b01, 20'h00300, 32'h0, 3'b000, 4'b0000);
        step();
        chk("to_issue_addr", maddr, 20'h00300);
        chk("to_issue_status", status, 6'b010001);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("to_wait_status", status, 6'b010001);
        end
        step();
        chk("to_done_status", status, 6'b110001);
        chk("to_done_rdata", rdata, 32'h0);
        set_client(2, 2'b00, 20'h0, 32'h0, 3'b000, 4'b0000);
        step();
        step();
        step();
        chk("to_next_vis", mvis, 2'b01);
        chk("to_next_addr", maddr, 20'h00010);
        step();
        mstat = 2'b10;
        mdata = 32'h00000005;
        step();
        chk("to_next_done", status, 6'b000010);
        chk("to_next_rdata", rdata, 32'h00000005);
        mstat = 2'b00;
        vis   = '0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-client arbiter between cache-side requesters (I-cache, D-cache, future vector/DMA ports) and the single main-memory port.
- Replaces the two fixed i_cache/d_cache request inputs on main memory with a generic, round-robin, one-transaction-at-a-time front end.
- Buffers the granted request, drives the memory port, captures the response and returns per-client status and read data.

Parameters:
- NUM_CLIENTS, 2, number of requesters, range 2..8.
- ADDR_WIDTH, 20, byte address width.
- DATA_LEN, 32, data word width.
- ENTRY_INDEX_SIZE, 3, write-length field width is ENTRY_INDEX_SIZE+1.
- TIMEOUT_CYCLES, 256, watchdog limit. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- client_vis_signal  in  2*NUM_CLIENTS  per-client request: 00 idle, 01 read, 10 write, 11 treated as idle.
- client_addr  in  ADDR_WIDTH*NUM_CLIENTS  per-client address.
- client_written_data  in  DATA_LEN*NUM_CLIENTS  per-client write data.
- client_data_type  in  3*NUM_CLIENTS  per-client access type, passed through.
- client_length  in  (ENTRY_INDEX_SIZE+1)*NUM_CLIENTS  per-client write length.
- client_status  out  2*NUM_CLIENTS  per-client status: 00 idle, 01 busy, 10 done, 11 error.
- client_rdata  out  DATA_LEN  read data, valid when any client_status slice is 10.
- mem_vis_signal  out  2  memory request: 00, 01 or 10.
- mem_vis_addr  out  ADDR_WIDTH  memory address.
- mem_written_data  out  DATA_LEN  memory write data.
- mem_data_type  out  3  memory access type.
- mem_write_length  out  ENTRY_INDEX_SIZE+1  memory write length.
- mem_data  in  DATA_LEN  memory read data.
- mem_status  in  2  memory status; 10 means done, all other codes are ignored.

Behaviour:
- Reset (rst=0, asynchronous): state returns to IDLE, rr_ptr=0, all outputs 0. An in-flight memory access is abandoned and no done pulse is issued.
- State machine states: IDLE, ISSUE, WAIT, DONE, RECOVER. All outputs are registered.
- IDLE:
  - Scan clients starting at rr_ptr, ascending with wrap. The first client with request 01 or 10 wins.
  - Latch grant index, op, addr, write data, type and length. Go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: mem_vis_signal = latched op for exactly one cycle. Addr, data, type and length are held from ISSUE until leaving WAIT. Go to WAIT.
- WAIT:
  - mem_vis_signal=00; addr and fields are held.
  - On mem_status==10, capture mem_data into the read-data register (write ops capture too, and the value is don't-care). Go to DONE.
- DONE:
  - Granted client's status = 10 for exactly one cycle.
  - client_rdata = captured data; it holds its value until the next capture.
  - rr_ptr <= (grant+1) mod NUM_CLIENTS. Go to RECOVER.
- RECOVER: one cycle with no sampling, so registered clients can drop a stale request. Go to IDLE.
- Status rules:
  - A requesting client that is not the active grant sees 01 while the state is not IDLE, and also in IDLE on a cycle it loses.
  - The granted client sees 01 in ISSUE and WAIT.
  - A non-requesting client sees 00.
- A client dropping or changing its request mid-transaction does not abort or alter the transaction; DONE is still pulsed to it.
- Simultaneous requests: exactly one grant per transaction. Round-robin guarantees every requester is served within NUM_CLIENTS transactions.
- Uncontended latency: request seen at edge 0, ISSUE at cycle 1, DONE at cycle 2+L (L = memory latency ≥1 cycle after ISSUE). The next grant comes at the earliest 2 cycles after DONE.
- Index arithmetic: rr_ptr width is max(1, clog2(NUM_CLIENTS)). Wrap is explicit for non-power-of-two NUM_CLIENTS.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYCLES cycles elapse without mem_status==10, go to DONE and assert status 11 (error) instead of 10; client_rdata is cleared to 0.
  - The counter clears on entering WAIT.
- Undefined: WAIT persists indefinitely, no counter logic exists, and TIMEOUT_CYCLES is ignored.

Test Plan:
- Reset: hold rst=0 with requests active -> all outputs 0; release -> first grant goes to client 0 if it is requesting.
- Single read: client1 read addr 0x00040, memory done 3 cycles after ISSUE with data 0xDEADBEEF -> mem_vis_signal=01 for one cycle, client_status[1]=10 for one cycle at cycle 5, client_rdata=0xDEADBEEF.
- Contention: NUM_CLIENTS=3, all clients request continuously -> grant order 0,1,2,0,1,2; no client gets two consecutive grants while others wait.
- Write pass-through: client0 write addr 0x00100, data 0x12345678, type 010, length 0001 -> mem outputs match these exactly from ISSUE through WAIT; done pulse delivered to client0 only.
- Reset mid-WAIT: assert rst during WAIT -> immediate return to IDLE, no done pulse, rr_ptr=0.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never responds -> client_status=11 for one cycle 8 cycles after entering WAIT; the next pending client is then granted normally.
